// File: rtl/hybrid_channel_arbiter.sv
// hybrid_channel_arbiter: fixed-priority (top NUM_HI) plus round-robin channel arbiter with bounded tenure.
// Define ARB_STARVE_GUARD_EN to add the round-robin starvation counter and non-preemptible boost.
module hybrid_channel_arbiter #(
  parameter int NUM_CH = 8,
  parameter int NUM_HI = 3,
  parameter int MAX_HOLD = 16,
  parameter int STARVE_LIMIT = 32,
  localparam int NUM_LO = NUM_CH - NUM_HI,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_id,
  output logic [NUM_CH-1:0] grant_onehot
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [NUM_CH-1:0] LO_MASK = {NUM_CH{1'b1}} >> NUM_HI;
  localparam logic [IDX_W-1:0] RR_TOP = IDX_W'(NUM_LO > 0 ? NUM_LO - 1 : 0);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] id_n, rr_ptr, rr_ptr_n, hi_id, rr_id, idx;
  logic [NUM_CH-1:0] oh_n, req_q, cand;
  logic [HW-1:0] hold_cnt, hold_n;
  logic hi_hit, rr_hit, win_lo, rel, preempt, expire, arb, boost, boosted;
  assign grant_valid = state == GRANT;
  // Preemption is triggered by a newly raised fixed request above the owner, so a
  // channel that merely stays asserted after losing on expiry cannot snatch the bus back.
  always_comb begin
    rel = grant_valid && !(|(req & grant_onehot));
    preempt = grant_valid && !boosted &&
              |(req & ~req_q & ~LO_MASK & ~(grant_onehot | (grant_onehot - 1'b1)));
    expire = grant_valid && hold_cnt == HW'(MAX_HOLD) && |(req & ~grant_onehot);
    arb = !grant_valid || rel || preempt || expire;
    cand = req & (expire ? ~grant_onehot : '1);
    hi_hit = 1'b0;
    hi_id = '0;
    for (int i = NUM_LO; i < NUM_CH; i++)
      if (cand[i]) begin
        hi_hit = 1'b1;
        hi_id = IDX_W'(i);
      end
    rr_hit = 1'b0;
    rr_id = '0;
    idx = '0;
    for (int k = NUM_LO - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_ptr) + NUM_LO - k) % NUM_LO);
      if (cand[idx]) begin
        rr_hit = 1'b1;
        rr_id = idx;
      end
    end
    win_lo = rr_hit && (boost || !hi_hit);
    state_n = state;
    id_n = grant_id;
    oh_n = grant_onehot;
    rr_ptr_n = rr_ptr;
    hold_n = hold_cnt == HW'(MAX_HOLD) ? HW'(1) : hold_cnt + 1'b1;
    if (arb) begin
      state_n = (hi_hit || rr_hit) ? GRANT : IDLE;
      id_n = win_lo ? rr_id : hi_id;
      oh_n = (hi_hit || rr_hit) ? NUM_CH'(1) << id_n : '0;
      hold_n = (hi_hit || rr_hit) ? HW'(1) : '0;
      if (win_lo) rr_ptr_n = rr_id == '0 ? RR_TOP : rr_id - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      grant_onehot <= '0;
      hold_cnt <= '0;
      rr_ptr <= RR_TOP;
      req_q <= '0;
    end else begin
      state <= state_n;
      grant_id <= id_n;
      grant_onehot <= oh_n;
      hold_cnt <= hold_n;
      rr_ptr <= rr_ptr_n;
      req_q <= req;
    end
`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  assign boost = starve_cnt == SW'(STARVE_LIMIT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      starve_cnt <= '0;
      boosted <= 1'b0;
    end else begin
      boosted <= arb ? win_lo && boost : boosted;
      starve_cnt <= (arb && win_lo) ? '0 :
                    (|(req & LO_MASK) && !(grant_valid && |(grant_onehot & LO_MASK)) && !boost) ?
                    starve_cnt + 1'b1 : starve_cnt;
    end
`else
  assign boost = 1'b0;
  assign boosted = 1'b0;
`endif
endmodule
